// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request in flight to instruction
// memory and offers the returned word to the IF/ID register, with a one-deep park slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCplus4Out,
    output logic [31:0] instructionOut,
    output logic        fetch_valid,
    output logic        if_flush
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] req_pc_reg, req_pc_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_instr_reg, out_instr_next;
    logic [31:0] out_pc4_reg, out_pc4_next;
    logic [31:0] hold_instr_reg, hold_instr_next;
    logic [31:0] hold_pc4_reg, hold_pc4_next;
    logic        consume;

    // The offer slot empties on any edge where IF/ID loads and no redirect flushes it.
    assign consume = out_valid_reg & pc_en & ~redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            req_pc_reg     <= RESET_PC;
            out_valid_reg  <= 1'b0;
            out_instr_reg  <= 32'h0;
            out_pc4_reg    <= 32'h0;
            hold_instr_reg <= 32'h0;
            hold_pc4_reg   <= 32'h0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_pc_reg     <= req_pc_next;
            out_valid_reg  <= out_valid_next;
            out_instr_reg  <= out_instr_next;
            out_pc4_reg    <= out_pc4_next;
            hold_instr_reg <= hold_instr_next;
            hold_pc4_reg   <= hold_pc4_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        req_pc_next     = req_pc_reg;
        out_valid_next  = out_valid_reg;
        out_instr_next  = out_instr_reg;
        out_pc4_next    = out_pc4_reg;
        hold_instr_next = hold_instr_reg;
        hold_pc4_next   = hold_pc4_reg;

        if (consume) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (!redirect) begin
                    req_pc_next = pc_reg;
                    pc_next     = pc_reg + 32'd4;
                    state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_next = imem_ack ? ST_IDLE : ST_DRAIN;
                end else if (imem_ack) begin
                    if (!out_valid_reg || consume) begin
                        out_valid_next = 1'b1;
                        out_instr_next = imem_rdata;
                        out_pc4_next   = req_pc_reg + 32'd4;
                        state_next     = ST_IDLE;
                    end else begin
                        hold_instr_next = imem_rdata;
                        hold_pc4_next   = req_pc_reg + 32'd4;
                        state_next      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_next = ST_IDLE;
                end else if (consume) begin
                    out_valid_next = 1'b1;
                    out_instr_next = hold_instr_reg;
                    out_pc4_next   = hold_pc4_reg;
                    state_next     = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // The stale response is swallowed even if a new redirect lands on it.
                if (imem_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (redirect) begin
            pc_next        = redirect_pc & ~32'h3;
            out_valid_next = 1'b0;
        end
    end

    // A redirect cancels the IDLE request in the same cycle, so imem_req is gated here.
    assign imem_req       = (state_reg == ST_IDLE) & ~redirect & ~rst;
    assign imem_addr      = pc_reg;
    assign fetch_valid    = out_valid_reg & ~rst;
    assign instructionOut = fetch_valid ? out_instr_reg : 32'h0;
    assign PCplus4Out     = rst ? 32'h0 : out_pc4_reg;
    assign if_flush       = redirect & ~rst;

endmodule
